// File: rtl/pipelined_control_unit.sv
// RV32I 5-stage pipeline control: decodes the ID opcode through control_unit and carries the bundle
// through ID/EX, EX/MEM and MEM/WB, with hazard stall, redirect flush, forwarding selects and event counters.

module control_unit (
  input  logic [6:0] opcode,
  output logic       write,
  output logic       store,
  output logic       load,
  output logic       branch,
  output logic [1:0] alu_operand_a_selector,  // 00 rs1, 01 pc, 10 zero
  output logic       alu_operand_b_selector,  // 0 rs2, 1 immediate
  output logic [1:0] immediate_selector,      // 00 I, 01 S, 10 B/J, 11 U
  output logic [1:0] next_pc_selector,        // 00 pc+4, 01 branch, 10 jal, 11 jalr
  output logic [2:0] alu_operations_selector  // 000 R funct, 001 I funct, 010 add, 011 compare, 100 link
);
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    write                   = 1'b0;
    store                   = 1'b0;
    load                    = 1'b0;
    branch                  = 1'b0;
    alu_operand_a_selector  = 2'b00;
    alu_operand_b_selector  = 1'b0;
    immediate_selector      = 2'b00;
    next_pc_selector        = 2'b00;
    alu_operations_selector = 3'b000;
    case (opcode)
      7'h33: write = 1'b1;
      7'h13: begin write = 1'b1; alu_operand_b_selector = 1'b1; alu_operations_selector = 3'b001; end
      7'h03: begin write = 1'b1; load = 1'b1; alu_operand_b_selector = 1'b1; alu_operations_selector = 3'b010; end
      7'h23: begin
        store = 1'b1; alu_operand_b_selector = 1'b1;
        immediate_selector = 2'b01; alu_operations_selector = 3'b010;
      end
      7'h63: begin
        branch = 1'b1; immediate_selector = 2'b10;
        next_pc_selector = 2'b01; alu_operations_selector = 3'b011;
      end
      7'h6F: begin
        write = 1'b1; alu_operand_a_selector = 2'b01; alu_operand_b_selector = 1'b1;
        immediate_selector = 2'b10; next_pc_selector = 2'b10; alu_operations_selector = 3'b100;
      end
      7'h67: begin
        write = 1'b1; alu_operand_a_selector = 2'b01; alu_operand_b_selector = 1'b1;
        next_pc_selector = 2'b11; alu_operations_selector = 3'b100;
      end
      7'h17: begin
        write = 1'b1; alu_operand_a_selector = 2'b01; alu_operand_b_selector = 1'b1;
        immediate_selector = 2'b11; alu_operations_selector = 3'b010;
      end
      7'h37: begin
        write = 1'b1; alu_operand_a_selector = 2'b10; alu_operand_b_selector = 1'b1;
        immediate_selector = 2'b11; alu_operations_selector = 3'b010;
      end
      default: ;
    endcase
  end
endmodule

module pipelined_control_unit #(
  parameter bit ENABLE_FORWARDING = 1'b1,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [6:0]                id_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      ex_redirect,
  output logic                      id_ex_valid,
  output logic                      id_ex_write,
  output logic                      id_ex_store,
  output logic                      id_ex_load,
  output logic                      id_ex_branch,
  output logic [1:0]                id_ex_alu_operand_a_selector,
  output logic                      id_ex_alu_operand_b_selector,
  output logic [1:0]                id_ex_immediate_selector,
  output logic [1:0]                id_ex_next_pc_selector,
  output logic [2:0]                id_ex_alu_operations_selector,
  output logic                      ex_mem_write,
  output logic                      ex_mem_load,
  output logic                      ex_mem_store,
  output logic                      mem_wb_write,
  output logic                      mem_wb_load,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  output logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
  output logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      stall,
  output logic                      flush_if_id,
  output logic                      illegal_opcode,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);
  logic                      dec_write, dec_store, dec_load, dec_branch, dec_b_sel;
  logic [1:0]                dec_a_sel, dec_imm_sel, dec_npc_sel;
  logic [2:0]                dec_alu_sel;
  logic                      legal, uses_rs1, uses_rs2, accept, hazard;
  logic                      ex_writes, mem_writes, wb_writes, rs1_ex_hit, rs2_ex_hit;
  logic                      ex_mem_valid, mem_wb_valid;
  logic [REG_ADDR_WIDTH-1:0] id_ex_rs1, id_ex_rs2;

  control_unit u_decode (
    .opcode                  (id_opcode),
    .write                   (dec_write),
    .store                   (dec_store),
    .load                    (dec_load),
    .branch                  (dec_branch),
    .alu_operand_a_selector  (dec_a_sel),
    .alu_operand_b_selector  (dec_b_sel),
    .immediate_selector      (dec_imm_sel),
    .next_pc_selector        (dec_npc_sel),
    .alu_operations_selector (dec_alu_sel)
  );

  always_comb begin
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      7'h33, 7'h23, 7'h63: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'h03, 7'h13, 7'h67: uses_rs1 = 1'b1;
      7'h17, 7'h37, 7'h6F: ;
      default:             legal = 1'b0;
    endcase
    uses_rs1 = uses_rs1 && id_valid;
    uses_rs2 = uses_rs2 && id_valid;
  end

  assign illegal_opcode = id_valid && !legal;

  // A stage only matters for hazards when it really writes a nonzero destination.
  assign ex_writes  = id_ex_valid  && id_ex_write  && (id_ex_rd  != '0);
  assign mem_writes = ex_mem_valid && ex_mem_write && (ex_mem_rd != '0);
  assign wb_writes  = mem_wb_valid && mem_wb_write && (mem_wb_rd != '0);
  assign rs1_ex_hit = uses_rs1 && ex_writes && (id_rs1 == id_ex_rd);
  assign rs2_ex_hit = uses_rs2 && ex_writes && (id_rs2 == id_ex_rd);

  generate
    if (ENABLE_FORWARDING) begin : g_fwd
      assign hazard    = id_ex_load && (rs1_ex_hit || rs2_ex_hit);
      assign forward_a = (mem_writes && ex_mem_rd == id_ex_rs1) ? 2'b01 :
                         (wb_writes  && mem_wb_rd == id_ex_rs1) ? 2'b10 : 2'b00;
      assign forward_b = (mem_writes && ex_mem_rd == id_ex_rs2) ? 2'b01 :
                         (wb_writes  && mem_wb_rd == id_ex_rs2) ? 2'b10 : 2'b00;
    end else begin : g_no_fwd
      assign hazard    = rs1_ex_hit || rs2_ex_hit ||
                         (uses_rs1 && mem_writes && id_rs1 == ex_mem_rd) ||
                         (uses_rs2 && mem_writes && id_rs2 == ex_mem_rd);
      assign forward_a = 2'b00;
      assign forward_b = 2'b00;
    end
  endgenerate

  assign flush_if_id = ex_redirect;
  assign stall       = hazard && !ex_redirect;
  assign accept      = id_valid && legal && !ex_redirect && !hazard;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch inside the clocked block.
    if (!rst_n || !accept) begin
      id_ex_valid                   <= 1'b0;
      id_ex_write                   <= 1'b0;
      id_ex_store                   <= 1'b0;
      id_ex_load                    <= 1'b0;
      id_ex_branch                  <= 1'b0;
      id_ex_alu_operand_a_selector  <= 2'b00;
      id_ex_alu_operand_b_selector  <= 1'b0;
      id_ex_immediate_selector      <= 2'b00;
      id_ex_next_pc_selector        <= 2'b00;
      id_ex_alu_operations_selector <= 3'b000;
      id_ex_rd                      <= '0;
      id_ex_rs1                     <= '0;
      id_ex_rs2                     <= '0;
    end else begin
      id_ex_valid                   <= 1'b1;
      id_ex_write                   <= dec_write;
      id_ex_store                   <= dec_store;
      id_ex_load                    <= dec_load;
      id_ex_branch                  <= dec_branch;
      id_ex_alu_operand_a_selector  <= dec_a_sel;
      id_ex_alu_operand_b_selector  <= dec_b_sel;
      id_ex_immediate_selector      <= dec_imm_sel;
      id_ex_next_pc_selector        <= dec_npc_sel;
      id_ex_alu_operations_selector <= dec_alu_sel;
      id_ex_rd                      <= id_rd;
      // Unused source fields are zeroed so they can never produce a spurious forward.
      id_ex_rs1                     <= uses_rs1 ? id_rs1 : '0;
      id_ex_rs2                     <= uses_rs2 ? id_rs2 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_valid <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_load  <= 1'b0;
      ex_mem_store <= 1'b0;
      ex_mem_rd    <= '0;
      mem_wb_valid <= 1'b0;
      mem_wb_write <= 1'b0;
      mem_wb_load  <= 1'b0;
      mem_wb_rd    <= '0;
    end else begin
      ex_mem_valid <= id_ex_valid;
      ex_mem_write <= id_ex_write;
      ex_mem_load  <= id_ex_load;
      ex_mem_store <= id_ex_store;
      ex_mem_rd    <= id_ex_rd;
      mem_wb_valid <= ex_mem_valid;
      mem_wb_write <= ex_mem_write;
      mem_wb_load  <= ex_mem_load;
      mem_wb_rd    <= ex_mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1)       stall_count <= stall_count + 1'b1;
      if (flush_if_id && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: one forwarding and one non-forwarding instance share stimulus; a stage-list
// reference model predicts every cycle's outputs and a negedge monitor compares them.

module tb_pipelined_control_unit;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic v, w, st, ld, br, sel_nz;
    logic mw, ml, ms, ww, wl;
    logic [RW-1:0] rd_ex, rd_mem, rd_wb;
    logic [1:0] fa, fb;
    logic stall, flush, illegal;
    logic [CW-1:0] sc, fc;
  } obs_t;

  typedef struct packed {
    logic v, w, ld, st, br;
    logic [RW-1:0] rd, rs1, rs2;
  } stage_t;

  typedef struct packed {
    logic legal, w, ld, st, br, u1, u2;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n, id_valid, ex_redirect;
  logic [6:0] id_opcode;
  logic [RW-1:0] id_rd, id_rs1, id_rs2;

  logic v_f, w_f, st_f, ld_f, br_f, bsel_f, mw_f, ml_f, ms_f, ww_f, wl_f, stall_f, flush_f, ill_f;
  logic [1:0] asel_f, isel_f, nsel_f, fa_f, fb_f;
  logic [2:0] osel_f;
  logic [RW-1:0] rdx_f, rdm_f, rdw_f;
  logic [CW-1:0] sc_f, fc_f;
  logic v_n, w_n, st_n, ld_n, br_n, bsel_n, mw_n, ml_n, ms_n, ww_n, wl_n, stall_n, flush_n, ill_n;
  logic [1:0] asel_n, isel_n, nsel_n, fa_n, fb_n;
  logic [2:0] osel_n;
  logic [RW-1:0] rdx_n, rdm_n, rdw_n;
  logic [CW-1:0] sc_n, fc_n;

  int vectors = 0;
  int miscompares = 0;
  obs_t q0[$];
  obs_t q1[$];
  stage_t ms[2][3];  // [instance][EX, MEM, WB]
  int sc_m[2];
  int fc_m[2];
  logic [6:0] legal_ops[9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};

  always #5 clk = ~clk;

  pipelined_control_unit #(.ENABLE_FORWARDING(1'b1), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
    .id_ex_valid(v_f), .id_ex_write(w_f), .id_ex_store(st_f), .id_ex_load(ld_f), .id_ex_branch(br_f),
    .id_ex_alu_operand_a_selector(asel_f), .id_ex_alu_operand_b_selector(bsel_f),
    .id_ex_immediate_selector(isel_f), .id_ex_next_pc_selector(nsel_f),
    .id_ex_alu_operations_selector(osel_f),
    .ex_mem_write(mw_f), .ex_mem_load(ml_f), .ex_mem_store(ms_f), .mem_wb_write(ww_f), .mem_wb_load(wl_f),
    .id_ex_rd(rdx_f), .ex_mem_rd(rdm_f), .mem_wb_rd(rdw_f), .forward_a(fa_f), .forward_b(fb_f),
    .stall(stall_f), .flush_if_id(flush_f), .illegal_opcode(ill_f), .stall_count(sc_f), .flush_count(fc_f)
  );

  pipelined_control_unit #(.ENABLE_FORWARDING(1'b0), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
    .id_ex_valid(v_n), .id_ex_write(w_n), .id_ex_store(st_n), .id_ex_load(ld_n), .id_ex_branch(br_n),
    .id_ex_alu_operand_a_selector(asel_n), .id_ex_alu_operand_b_selector(bsel_n),
    .id_ex_immediate_selector(isel_n), .id_ex_next_pc_selector(nsel_n),
    .id_ex_alu_operations_selector(osel_n),
    .ex_mem_write(mw_n), .ex_mem_load(ml_n), .ex_mem_store(ms_n), .mem_wb_write(ww_n), .mem_wb_load(wl_n),
    .id_ex_rd(rdx_n), .ex_mem_rd(rdm_n), .mem_wb_rd(rdw_n), .forward_a(fa_n), .forward_b(fb_n),
    .stall(stall_n), .flush_if_id(flush_n), .illegal_opcode(ill_n), .stall_count(sc_n), .flush_count(fc_n)
  );

  task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", name, inst, $time, got, exp);
    end
  endtask

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      7'h33:               begin d.w = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      7'h03:               begin d.w = 1'b1; d.ld = 1'b1; d.u1 = 1'b1; end
      7'h13, 7'h67:        begin d.w = 1'b1; d.u1 = 1'b1; end
      7'h23:               begin d.st = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      7'h63:               begin d.br = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      7'h17, 7'h37, 7'h6F: d.w = 1'b1;
      default:             d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic writes(input stage_t s);
    return s.v && s.w && (s.rd != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input int c, input logic [RW-1:0] rs);
    if (writes(ms[c][1]) && ms[c][1].rd == rs) return 2'b01;
    if (writes(ms[c][2]) && ms[c][2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic obs_t observe(input int c);
    obs_t a;
    if (c == 0)
      a = '{v_f, w_f, st_f, ld_f, br_f, (|{asel_f, bsel_f, isel_f, nsel_f, osel_f}), mw_f, ml_f, ms_f, ww_f,
            wl_f, rdx_f, rdm_f, rdw_f, fa_f, fb_f, stall_f, flush_f, ill_f, sc_f, fc_f};
    else
      a = '{v_n, w_n, st_n, ld_n, br_n, (|{asel_n, bsel_n, isel_n, nsel_n, osel_n}), mw_n, ml_n, ms_n, ww_n,
            wl_n, rdx_n, rdm_n, rdw_n, fa_n, fb_n, stall_n, flush_n, ill_n, sc_n, fc_n};
    return a;
  endfunction

  // Drive one ID cycle, queue the expected outputs for both instances, then advance the model.
  task automatic step(input logic v, input logic [6:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] r1,
                      input logic [RW-1:0] r2, input logic redir, input logic rst);
    dec_t d;
    logic real_i, u1, u2, hz;
    obs_t e;
    @(posedge clk);
    #1;
    rst_n = !rst; id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = r1; id_rs2 = r2; ex_redirect = redir;
    d = decode(op);
    real_i = v && d.legal;
    u1 = real_i && d.u1;
    u2 = real_i && d.u2;
    for (int c = 0; c < 2; c++) begin
      hz = 1'b0;
      // With forwarding only a load in EX blocks; without it, any writer in EX or MEM does.
      for (int s = 0; s < ((c == 0) ? 1 : 2); s++)
        if (writes(ms[c][s]) && (c == 1 || ms[c][s].ld) &&
            ((u1 && r1 == ms[c][s].rd) || (u2 && r2 == ms[c][s].rd)))
          hz = 1'b1;
      e = '0;
      e.v = ms[c][0].v; e.w = ms[c][0].w; e.st = ms[c][0].st; e.ld = ms[c][0].ld; e.br = ms[c][0].br;
      e.mw = ms[c][1].w; e.ml = ms[c][1].ld; e.ms = ms[c][1].st;
      e.ww = ms[c][2].w; e.wl = ms[c][2].ld;
      e.rd_ex = ms[c][0].rd; e.rd_mem = ms[c][1].rd; e.rd_wb = ms[c][2].rd;
      if (c == 0) begin
        e.fa = fwd_sel(c, ms[c][0].rs1);
        e.fb = fwd_sel(c, ms[c][0].rs2);
      end
      e.stall = hz && !redir;
      e.flush = redir;
      e.illegal = v && !d.legal;
      e.sc = CW'(sc_m[c]);
      e.fc = CW'(fc_m[c]);
      if (c == 0) q0.push_back(e); else q1.push_back(e);
      if (rst) begin
        for (int s = 0; s < 3; s++) ms[c][s] = '0;
        sc_m[c] = 0;
        fc_m[c] = 0;
      end else begin
        ms[c][2] = ms[c][1];
        ms[c][1] = ms[c][0];
        ms[c][0] = '0;
        if (real_i && !redir && !hz) begin
          ms[c][0].v = 1'b1; ms[c][0].w = d.w; ms[c][0].ld = d.ld; ms[c][0].st = d.st; ms[c][0].br = d.br;
          ms[c][0].rd = rd;
          ms[c][0].rs1 = u1 ? r1 : '0;
          ms[c][0].rs2 = u2 ? r2 : '0;
        end
        if (e.stall && sc_m[c] < CNT_MAX) sc_m[c]++;
        if (redir && fc_m[c] < CNT_MAX) fc_m[c]++;
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'h00, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_cycle();
    step(1'b0, 7'h00, '0, '0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle each instance presents a full output set; compare against the queue head.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if ((c == 0 && q0.size() > 0) || (c == 1 && q1.size() > 0)) begin
          e = (c == 0) ? q0.pop_front() : q1.pop_front();
          a = observe(c);
          check("ex_ctrl", c, 32'({a.v, a.w, a.st, a.ld, a.br}), 32'({e.v, e.w, e.st, e.ld, e.br}));
          if (!e.v) check("ex_sel_bubble", c, 32'(a.sel_nz), 32'(0));
          check("id_ex_rd", c, 32'(a.rd_ex), 32'(e.rd_ex));
          check("mem_stage", c, 32'({a.mw, a.ml, a.ms, a.rd_mem}), 32'({e.mw, e.ml, e.ms, e.rd_mem}));
          check("wb_stage", c, 32'({a.ww, a.wl, a.rd_wb}), 32'({e.ww, e.wl, e.rd_wb}));
          check("forward", c, 32'({a.fa, a.fb}), 32'({e.fa, e.fb}));
          check("stall_flush_illegal", c, 32'({a.stall, a.flush, a.illegal}), 32'({e.stall, e.flush, e.illegal}));
          check("stall_count", c, 32'(a.sc), 32'(e.sc));
          check("flush_count", c, 32'(a.fc), 32'(e.fc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0; ex_redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) ms[c][s] = '0;
      sc_m[c] = 0;
      fc_m[c] = 0;
    end

    // ADD x3 walks through EX, MEM, WB on consecutive edges.
    reset_cycle();
    step(1'b1, 7'h33, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    nop(4);

    // LW x5 then ADD x6,x5,x1 held in ID until accepted.
    reset_cycle();
    step(1'b1, 7'h03, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 7'h33, 5'd6, 5'd5, 5'd1, 1'b0, 1'b0);
    nop(2);
    #1;
    check("loaduse_stalls_fwd", 0, 32'(sc_f), 32'd1);
    check("loaduse_stalls_nofwd", 1, 32'(sc_n), 32'd2);
    nop(2);

    // x0 destination never hazards; two x7 writers then a consumer of x7.
    reset_cycle();
    step(1'b1, 7'h13, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 7'h33, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 7'h13, 5'd7, 5'd1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 7'h13, 5'd7, 5'd2, 5'd0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 7'h33, 5'd8, 5'd7, 5'd7, 1'b0, 1'b0);
    nop(4);

    // Redirect arriving during a load-use stall.
    reset_cycle();
    step(1'b1, 7'h03, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 7'h33, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0);
    #1;
    check("redirect_kills_stall", 0, 32'({stall_f, flush_f}), 32'b01);
    nop(1);
    #1;
    check("redirect_bubble_count", 0, 32'({v_f, fc_f}), 32'd1);

    // Illegal opcode becomes a bubble.
    step(1'b1, 7'h7F, 5'd9, 5'd1, 5'd2, 1'b0, 1'b0);
    #1;
    check("illegal_flag", 0, 32'(ill_f), 32'd1);
    nop(1);
    #1;
    check("illegal_bubble", 0, 32'(v_f), 32'd0);

    // Twenty load-use pairs drive both stall counters into saturation.
    reset_cycle();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 7'h03, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
      step(1'b1, 7'h33, 5'd3, 5'd1, 5'd1, 1'b0, 1'b0);
    end
    nop(3);
    #1;
    check("stall_sat_fwd", 0, 32'(sc_f), 32'(CNT_MAX));
    check("stall_sat_nofwd", 1, 32'(sc_n), 32'(CNT_MAX));

    // Randomized traffic with a small register range to make hazards frequent.
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 8)] : 7'($urandom);
      step(($urandom_range(0, 9) != 0), op, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
           RW'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end
    nop(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
